// File: rtl/step_executor.sv
// Stepper command executor: buffers unit-step direction commands and turns each
// one into DIR setup, a STEP pulse and a gap, while tracking the 8-bit pen position.
module step_executor #(
    parameter int DEPTH         = 4,
    parameter int SETUP_CYCLES  = 10,
    parameter int PULSE_CYCLES  = 50,
    parameter int PERIOD_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dirx,
    input  logic [1:0] cmd_diry,
    output logic       cmd_ready,
    input  logic       pos_load,
    input  logic [7:0] load_x,
    input  logic [7:0] load_y,
    output logic       step_x,
    output logic       dir_x,
    output logic       step_y,
    output logic       dir_y,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y,
    output logic       busy
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (SETUP_CYCLES > PERIOD_CYCLES) ? SETUP_CYCLES : PERIOD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(PERIOD_CYCLES - PULSE_CYCLES - 1);

    // FIFO entry layout: {sx, mx, sy, my}
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_entry;
    logic          r_step_x;
    logic          r_step_y;
    logic          r_dir_x;
    logic          r_dir_y;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_new_entry;
    logic [3:0]    w_head;
    logic [CW-1:0] w_cnt_last;
    logic          w_cnt_done;
    logic          w_step_edge;
    logic          w_load;
    logic [1:0][7:0] w_load_val;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full && !rst;

    // All-zero commands complete the handshake but never occupy a FIFO slot.
    assign w_push      = cmd_valid && cmd_ready && ((cmd_dirx != 2'b00) || (cmd_diry != 2'b00));
    assign w_new_entry = {cmd_dirx[1], |cmd_dirx, cmd_diry[1], |cmd_diry};
    assign w_head      = r_mem[r_rptr];

    always_comb begin
        w_cnt_last = '0;
        case (r_state)
            S_SETUP: w_cnt_last = SETUP_LAST;
            S_PULSE: w_cnt_last = PULSE_LAST;
            S_GAP:   w_cnt_last = GAP_LAST;
            default: w_cnt_last = '0;
        endcase
    end

    assign w_cnt_done  = (r_cnt == w_cnt_last);
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_GAP) && w_cnt_done));
    assign w_step_edge = (r_state == S_SETUP) && w_cnt_done;
    assign w_load      = pos_load && (r_state == S_IDLE) && w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One shared counter times every phase; it restarts whenever a phase ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_entry  <= '0;
            r_step_x <= 1'b0;
            r_step_y <= 1'b0;
            r_dir_x  <= 1'b0;
            r_dir_y  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_done ? '0 : r_cnt + CW'(1);
            if (w_pop) begin
                r_entry <= w_head;
                r_dir_x <= w_head[3];
                r_dir_y <= w_head[1];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_state  <= S_PULSE;
                        r_step_x <= r_entry[2];
                        r_step_y <= r_entry[0];
                    end
                end
                S_PULSE: begin
                    if (w_cnt_done) begin
                        r_state  <= S_GAP;
                        r_step_x <= 1'b0;
                        r_step_y <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (w_cnt_done) begin
                        r_state <= w_empty ? S_IDLE : S_SETUP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_load_val = {load_x, load_y};

    // Axis 0 is Y (entry bits 1:0), axis 1 is X (entry bits 3:2).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [7:0] r_pos;
            logic       w_move;
            logic       w_neg;

            assign w_move = r_entry[2*gi];
            assign w_neg  = r_entry[2*gi+1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pos <= 8'd0;
                end else if (w_load) begin
                    r_pos <= w_load_val[gi];
                end else if (w_step_edge && w_move) begin
                    r_pos <= w_neg ? (r_pos - 8'd1) : (r_pos + 8'd1);
                end
            end
        end
    endgenerate

    assign pos_x  = g_axis[1].r_pos;
    assign pos_y  = g_axis[0].r_pos;
    assign step_x = r_step_x;
    assign step_y = r_step_y;
    assign dir_x  = r_dir_x;
    assign dir_y  = r_dir_y;
    assign busy   = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_step_executor.sv
// Bench for step_executor: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based schedule model of the command stream.
module tb_step_executor;

    localparam int DEPTH  = 4;
    localparam int SETUP  = 1;
    localparam int PULSE  = 2;
    localparam int PERIOD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dirx = 2'b00;
    logic [1:0] cmd_diry = 2'b00;
    logic       pos_load = 1'b0;
    logic [7:0] load_x = 8'h00;
    logic [7:0] load_y = 8'h00;
    logic       cmd_ready;
    logic       step_x, dir_x, step_y, dir_y, busy;
    logic [7:0] pos_x, pos_y;

    step_executor #(
        .DEPTH        (DEPTH),
        .SETUP_CYCLES (SETUP),
        .PULSE_CYCLES (PULSE),
        .PERIOD_CYCLES(PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_dirx (cmd_dirx),
        .cmd_diry (cmd_diry),
        .cmd_ready(cmd_ready),
        .pos_load (pos_load),
        .load_x   (load_x),
        .load_y   (load_y),
        .step_x   (step_x),
        .dir_x    (dir_x),
        .step_y   (step_y),
        .dir_y    (dir_y),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Schedule model: each command occupies [start, start+SETUP+PERIOD) edges.
    int m_cyc    = 0;
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_dx     = 0;
    int m_dy     = 0;
    int m_posx   = 0;
    int m_posy   = 0;
    bit m_dirx   = 1'b0;
    bit m_diry   = 1'b0;
    int q_dx[$];
    int q_dy[$];
    int accepted = 0;
    int rises[$];
    bit prev_sx  = 1'b0;

    function automatic int decode(input logic [1:0] f);
        if (f == 2'b00) return 0;
        else if (f == 2'b01) return 1;
        else return -1;
    endfunction

    function automatic bit exp_step(input int d);
        return m_active && (d != 0) && (m_cyc >= m_start + SETUP) && (m_cyc < m_start + SETUP + PULSE);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_edge();
        int  qsz;
        bit  was_idle;
        bit  ready;
        int  dx;
        int  dy;
        m_cyc++;
        if (rst) begin
            q_dx.delete();
            q_dy.delete();
            m_active = 1'b0;
            m_posx   = 0;
            m_posy   = 0;
            m_dirx   = 1'b0;
            m_diry   = 1'b0;
            return;
        end
        qsz      = q_dx.size();
        was_idle = !m_active;
        ready    = (qsz < DEPTH);
        if (m_active && (m_cyc == m_start + SETUP)) begin
            m_posx = (m_posx + m_dx) & 255;
            m_posy = (m_posy + m_dy) & 255;
        end
        if (m_active && (m_cyc == m_start + SETUP + PERIOD)) m_active = 1'b0;
        if (!m_active && (qsz > 0)) begin
            m_dx     = q_dx.pop_front();
            m_dy     = q_dy.pop_front();
            m_start  = m_cyc;
            m_active = 1'b1;
            m_dirx   = (m_dx < 0);
            m_diry   = (m_dy < 0);
        end
        if (was_idle && (qsz == 0) && pos_load) begin
            m_posx = load_x;
            m_posy = load_y;
        end
        if (cmd_valid && ready) begin
            accepted++;
            dx = decode(cmd_dirx);
            dy = decode(cmd_diry);
            $display("cycle %0d: command accepted dx=%0d dy=%0d", m_cyc, dx, dy);
            if ((dx != 0) || (dy != 0)) begin
                q_dx.push_back(dx);
                q_dy.push_back(dy);
            end
        end
    endtask

    task automatic check_all();
        chk("step_x", step_x, 8'(exp_step(m_dx)));
        chk("step_y", step_y, 8'(exp_step(m_dy)));
        chk("dir_x", dir_x, 8'(m_dirx));
        chk("dir_y", dir_y, 8'(m_diry));
        chk("pos_x", pos_x, 8'(m_posx));
        chk("pos_y", pos_y, 8'(m_posy));
        chk("busy", busy, 8'(m_active || (q_dx.size() > 0)));
        chk("cmd_ready", cmd_ready, 8'((q_dx.size() < DEPTH) && !rst));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (step_x && !prev_sx) rises.push_back(m_cyc);
        prev_sx = step_x;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && (n < bound)) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", busy, 8'h00);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        pos_load  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit saw_ready_low;

        // Reset state
        do_reset();
        chk("rst_busy", busy, 8'h00);
        chk("rst_pos_x", pos_x, 8'h00);

        // Single +X command at edge k
        cmd_valid = 1'b1; cmd_dirx = 2'b01; cmd_diry = 2'b00;
        tick();                                       // k
        cmd_valid = 1'b0;
        tick(); chk("t1_dir_x_k1", dir_x, 8'h00);     // k+1
        tick(); chk("t1_step_k2", step_x, 8'h01);     // k+2
        chk("t1_pos_x_k2", pos_x, 8'h01);
        chk("t1_pos_y_k2", pos_y, 8'h00);
        tick(); chk("t1_step_k3", step_x, 8'h01);     // k+3
        tick(); chk("t1_step_k4", step_x, 8'h00);     // k+4
        tick(); tick(); chk("t1_busy_k6", busy, 8'h01);
        tick(); chk("t1_busy_k7", busy, 8'h00);

        // Six back-to-back diagonal commands with cmd_valid held
        do_reset();
        rises.delete();
        accepted = 0;
        saw_ready_low = 1'b0;
        cmd_valid = 1'b1; cmd_dirx = 2'b11; cmd_diry = 2'b01;
        n = 0;
        while ((accepted < 6) && (n < 100)) begin
            tick();
            if (!cmd_ready) saw_ready_low = 1'b1;
            n++;
        end
        cmd_valid = 1'b0;
        chk("t2_accepted", 8'(accepted), 8'd6);
        chk("t2_ready_low_seen", 8'(saw_ready_low), 8'h01);
        wait_idle(100);
        chk("t2_rise_count", 8'(rises.size()), 8'd6);
        for (int i = 1; i < rises.size(); i++) begin
            chk("t2_rise_spacing", 8'(rises[i] - rises[i-1]), 8'd6);
        end
        chk("t2_final_pos_x", pos_x, 8'd250);
        chk("t2_final_pos_y", pos_y, 8'd6);

        // Position load in IDLE, then a wrapping diagonal step
        pos_load = 1'b1; load_x = 8'hFF; load_y = 8'h00;
        tick();
        pos_load = 1'b0;
        chk("t3_load_x", pos_x, 8'hFF);
        chk("t3_load_y", pos_y, 8'h00);
        cmd_valid = 1'b1; cmd_dirx = 2'b01; cmd_diry = 2'b10;
        tick();
        cmd_valid = 1'b0;
        wait_idle(50);
        chk("t3_wrap_x", pos_x, 8'h00);
        chk("t3_wrap_y", pos_y, 8'hFF);
        chk("t3_dir_y", dir_y, 8'h01);

        // Position load while busy is ignored
        cmd_valid = 1'b1; cmd_dirx = 2'b01; cmd_diry = 2'b00;
        tick();
        cmd_valid = 1'b0;
        pos_load = 1'b1; load_x = 8'h55; load_y = 8'h55;
        tick(); tick(); tick();
        pos_load = 1'b0;
        wait_idle(50);
        chk("t4_ignored_x", pos_x, 8'h01);
        chk("t4_ignored_y", pos_y, 8'hFF);

        // All-zero command: accepted, no motion
        cmd_valid = 1'b1; cmd_dirx = 2'b00; cmd_diry = 2'b00;
        chk("t5_ready", cmd_ready, 8'h01);
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("t5_busy", busy, 8'h00);
        chk("t5_step", step_x, 8'h00);

        // Reset during PULSE
        cmd_valid = 1'b1; cmd_dirx = 2'b01; cmd_diry = 2'b01;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!step_x && (n < 20)) begin
            tick();
            n++;
        end
        chk("t6_step_seen", step_x, 8'h01);
        rst = 1'b1;
        tick();
        chk("t6_rst_step_x", step_x, 8'h00);
        chk("t6_rst_step_y", step_y, 8'h00);
        chk("t6_rst_pos_x", pos_x, 8'h00);
        rst = 1'b0;
        tick();
        chk("t6_busy_after", busy, 8'h00);
        cmd_valid = 1'b1; cmd_dirx = 2'b10; cmd_diry = 2'b00;
        tick();
        cmd_valid = 1'b0;
        wait_idle(50);
        chk("t6_after_pos_x", pos_x, 8'hFF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_dirx  = 2'($urandom_range(0, 3));
            cmd_diry  = 2'($urandom_range(0, 3));
            pos_load  = ($urandom_range(0, 9) == 0);
            load_x    = 8'($urandom_range(0, 255));
            load_y    = 8'($urandom_range(0, 255));
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; cmd_valid = 1'b0; pos_load = 1'b0;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_executor.md
Name: step_executor

Overview:
- Receiver end of the per-step direction command stream (dirx/diry, one unit step per command) produced by the plotter's line generators.
- Queues commands in a small FIFO and converts each into timed STEP/DIR pulses for the X and Y stepper drivers.
- Tracks the absolute pen position in the same 8-bit coordinate space the line generators use.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- SETUP_CYCLES, 10, cycles DIR must be stable before STEP rises (≥1).
- PULSE_CYCLES, 50, STEP high time (≥1).
- PERIOD_CYCLES, 200, STEP high plus low time per step (>PULSE_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_dirx  in  2  X command: 2'b01 = +1; 2'b10 or 2'b11 = -1; 2'b00 = no move.
- cmd_diry  in  2  Y command, same encoding as cmd_dirx.
- cmd_ready  out  1  command can be accepted.
- pos_load  in  1  load the position registers.
- load_x  in  8  X value for pos_load.
- load_y  in  8  Y value for pos_load.
- step_x  out  1  X driver STEP.
- dir_x  out  1  X driver DIR (1 = negative).
- step_y  out  1  Y driver STEP.
- dir_y  out  1  Y driver DIR (1 = negative).
- pos_x  out  8  current X position.
- pos_y  out  8  current Y position.
- busy  out  1  FIFO non-empty or state != IDLE.

Behaviour:
- Reset (sync, active-high): FIFO flushed; state IDLE; step_x, step_y, dir_x, dir_y, pos_x, pos_y = 0; busy = 0. Reset asserted mid-pulse drops STEP at that same edge; the in-flight step is lost and the position is not corrected.
- cmd_ready = !full && !rst, combinational.
- Handshake: a transfer occurs at an edge where cmd_valid && cmd_ready. A command with both fields 2'b00 is accepted and discarded (no FIFO write). A full FIFO holds cmd_ready low even if a pop occurs in the same cycle (no pass-through).
- Entry = {sx, mx, sy, my}: m = (field != 0); s = field[1].
- FSM, with one counter sized for max(SETUP_CYCLES, PERIOD_CYCLES):
  - IDLE: if FIFO non-empty, pop, latch entry, set dir_x = sx and dir_y = sy, go to SETUP. dir outputs hold their last value otherwise.
  - SETUP: stay SETUP_CYCLES cycles, then go to PULSE. At the entering edge, set step_x = mx and step_y = my. Update the position at that same edge: pos += 1 if moving and s = 0; pos -= 1 if moving and s = 1. Arithmetic is 8-bit modulo (255+1 = 0, 0-1 = 255).
  - PULSE: stay PULSE_CYCLES cycles, then go to GAP with both STEP low.
  - GAP: stay PERIOD_CYCLES - PULSE_CYCLES cycles. At exit, if FIFO non-empty, pop and go directly to SETUP with new DIR values; else go to IDLE.
- Latency:
  - Transfer at edge k: SETUP and DIR valid at edge k+1; STEP rises at edge k+1+SETUP_CYCLES.
  - Back-to-back STEP rises are spaced SETUP_CYCLES + PERIOD_CYCLES cycles apart.
- X and Y steps from one entry pulse simultaneously (diagonal).
- pos_load is honoured only in IDLE with the FIFO empty: pos <= load value at the next edge. Otherwise it is ignored. A pop in IDLE takes priority over pos_load.
- A simultaneous push and pop with the FIFO non-full leaves the count unchanged.

Test Plan (SETUP_CYCLES=1, PULSE_CYCLES=2, PERIOD_CYCLES=5, DEPTH=4):
- Reset, then a single command dirx=01, diry=00 at edge k:
  - dir_x = 0 at k+1.
  - step_x high over edges k+2..k+3, low at k+4.
  - pos_x 0→1 at k+2; pos_y stays 0.
  - busy falls at k+7.
- Six back-to-back commands dirx=11, diry=01 with cmd_valid held high:
  - cmd_ready low while 4 entries are held.
  - Step rises 6 cycles apart.
  - Final pos_x = 250 (wrap from 0), pos_y = 6.
- pos_load with load_x=0xFF, load_y=0x00 in IDLE, then dirx=01, diry=10:
  - pos becomes (0xFF, 0x00), then (0x00, 0xFF).
  - Both STEP lines pulse together; dir_y = 1.
- pos_load asserted while busy with load_x=0x55 → ignored; position changes only by steps.
- cmd with dirx=00, diry=00 → cmd_ready high; no pulses; busy stays 0.
- rst asserted during PULSE:
  - step_x and step_y = 0 and pos = 0 at that edge.
  - FIFO empty afterwards; a subsequent command executes normally from IDLE.
